// File: rtl/rr_grant_arbiter_pkg.sv
// Shared types and helpers for the round-robin grant arbiter.
package rr_arb_pkg;

    typedef enum logic [0:0] {ARB_IDLE, ARB_GRANT} arb_state_t;

    // Helpers work on a fixed wide vector; callers size-cast to request_lines.
    localparam int MAX_LINES = 64;

    // Thermometer mask: bit i is set for every position strictly above ptr.
    function automatic logic [MAX_LINES-1:0] thermo_mask(input int ptr);
        logic [MAX_LINES-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_LINES; i++) begin
            m[i] = (i > ptr);
        end
        return m;
    endfunction

    // Binary index of a one-hot vector (0 for an all-zero vector).
    function automatic int onehot_to_idx(input logic [MAX_LINES-1:0] oh);
        int idx;
        idx = 0;
        for (int i = 0; i < MAX_LINES; i++) begin
            if (oh[i]) idx = idx | i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_grant_arbiter_if.sv
// Request/grant bundle between the requesters and the arbiter.
interface rr_grant_arbiter_if #(
    parameter int request_lines = 4
);
    localparam int IDX_W = $clog2(request_lines);

    logic [request_lines-1:0] req;
    logic                     release_gnt;
    logic [request_lines-1:0] gnt;
    logic                     gnt_valid;
    logic [IDX_W-1:0]         gnt_idx;

    modport master (
        output req,
        output release_gnt,
        input  gnt,
        input  gnt_valid,
        input  gnt_idx
    );

    modport slave (
        input  req,
        input  release_gnt,
        output gnt,
        output gnt_valid,
        output gnt_idx
    );
endinterface

// File: rtl/rr_grant_arbiter_pick.sv
// Combinational round-robin pick: lowest request above ptr, else lowest overall.
module rr_masked_priority_pick
    import rr_arb_pkg::*;
#(
    parameter int request_lines = 4
) (
    input  logic [request_lines-1:0]         i_req,
    input  logic [$clog2(request_lines)-1:0] i_ptr,
    output logic [request_lines-1:0]         o_pick,
    output logic                             o_found
);

    logic [request_lines-1:0] w_mask;
    logic [request_lines-1:0] w_masked;

    function automatic logic [request_lines-1:0] lowest_bit(input logic [request_lines-1:0] x);
        logic [request_lines-1:0] r;
        logic                     done;
        r    = '0;
        done = 1'b0;
        for (int i = 0; i < request_lines; i++) begin
            if (x[i] && !done) begin
                r[i] = 1'b1;
                done = 1'b1;
            end
        end
        return r;
    endfunction

    assign w_mask   = request_lines'(thermo_mask(int'(i_ptr)));
    assign w_masked = i_req & w_mask;
    // Nothing above the pointer requesting: wrap around to the lowest requester.
    assign o_pick   = (|w_masked) ? lowest_bit(w_masked) : lowest_bit(i_req);
    assign o_found  = |i_req;

endmodule

// File: rtl/rr_grant_arbiter.sv
// Registered round-robin arbiter holding a one-hot grant until release.
// request_lines must lie in 2..MAX_LINES.
module rr_grant_arbiter
    import rr_arb_pkg::*;
#(
    parameter int request_lines = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    rr_grant_arbiter_if.slave       io_arb
);

    localparam int IDX_W = $clog2(request_lines);

    arb_state_t               r_state;
    logic [IDX_W-1:0]         r_ptr;
    logic [request_lines-1:0] r_gnt;
    logic                     r_gnt_valid;
    logic [IDX_W-1:0]         r_gnt_idx;

    logic [request_lines-1:0] w_pick_req;
    logic [request_lines-1:0] w_pick;
    logic                     w_found;
    logic [IDX_W-1:0]         w_pick_idx;
    logic                     w_end;

    // r_gnt is zero in ARB_IDLE, so one masked pick serves both states and
    // keeps a released grantee out of its own handoff.
    assign w_pick_req = io_arb.req & ~r_gnt;
    assign w_pick_idx = IDX_W'(onehot_to_idx(MAX_LINES'(w_pick)));
    assign w_end      = io_arb.release_gnt | ~io_arb.req[r_gnt_idx];

    rr_masked_priority_pick #(
        .request_lines (request_lines)
    ) u_pick (
        .i_req   (w_pick_req),
        .i_ptr   (r_ptr),
        .o_pick  (w_pick),
        .o_found (w_found)
    );

    // Arbitration FSM: grant from idle, hold, then hand off or drop to idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ARB_IDLE;
            r_ptr       <= IDX_W'(request_lines - 1);
            r_gnt       <= '0;
            r_gnt_valid <= 1'b0;
            r_gnt_idx   <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_found) begin
                        r_gnt       <= w_pick;
                        r_gnt_valid <= 1'b1;
                        r_gnt_idx   <= w_pick_idx;
                        r_ptr       <= w_pick_idx;
                        r_state     <= ARB_GRANT;
                    end
                end
                ARB_GRANT: begin
                    if (w_end) begin
                        if (w_found) begin
                            r_gnt       <= w_pick;
                            r_gnt_valid <= 1'b1;
                            r_gnt_idx   <= w_pick_idx;
                            r_ptr       <= w_pick_idx;
                        end else begin
                            r_gnt       <= '0;
                            r_gnt_valid <= 1'b0;
                            r_gnt_idx   <= '0;
                            r_state     <= ARB_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= ARB_IDLE;
                end
            endcase
        end
    end

    assign io_arb.gnt       = r_gnt;
    assign io_arb.gnt_valid = r_gnt_valid;
    assign io_arb.gnt_idx   = r_gnt_idx;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Bench for rr_grant_arbiter: directed scenarios plus random traffic
// against a rotating-search reference model.
module tb_rr_grant_arbiter;

    localparam int N = 4;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    // Reference model: granted index (-1 = none) and last-winner pointer.
    int   m_idx;
    int   m_ptr;

    rr_grant_arbiter_if #(.request_lines(N)) arb_if ();

    rr_grant_arbiter #(
        .request_lines (N)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .io_arb (arb_if)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Search requesters in rotation order starting just after ptr.
    function automatic int rr_pick(input logic [N-1:0] r, input int ptr);
        int c;
        for (int k = 1; k <= N; k++) begin
            c = (ptr + k) % N;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_step(input logic [N-1:0] rq, input logic rel, input logic rs);
        logic [N-1:0] r2;
        int           p;
        if (rs) begin
            m_idx = -1;
            m_ptr = N - 1;
        end else if (m_idx < 0) begin
            p = rr_pick(rq, m_ptr);
            if (p >= 0) begin
                m_idx = p;
                m_ptr = p;
            end
        end else if (rel || !rq[m_idx]) begin
            r2        = rq;
            r2[m_idx] = 1'b0;
            p         = rr_pick(r2, m_ptr);
            m_idx     = p;
            if (p >= 0) m_ptr = p;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, advance model, compare all outputs after the edge.
    task automatic cycle(input logic [N-1:0] rq, input logic rel, input logic rs);
        logic [N-1:0] eg;
        arb_if.req         = rq;
        arb_if.release_gnt = rel;
        rst                = rs;
        @(posedge clk);
        model_step(rq, rel, rs);
        #1;
        eg = (m_idx < 0) ? '0 : N'(1 << m_idx);
        check("model_gnt",   32'(arb_if.gnt),       32'(eg));
        check("model_valid", 32'(arb_if.gnt_valid), 32'(m_idx >= 0));
        check("model_idx",   32'(arb_if.gnt_idx),   (m_idx < 0) ? 32'd0 : 32'(m_idx));
    endtask

    logic [N-1:0] sat_exp [4];

    initial begin
        clk                = 1'b0;
        rst                = 1'b1;
        arb_if.req         = '0;
        arb_if.release_gnt = 1'b0;
        n_checks           = 0;
        n_fail             = 0;
        m_idx              = -1;
        m_ptr              = N - 1;
        sat_exp            = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};

        // Reset state
        cycle(4'b0000, 1'b0, 1'b1);
        check("reset_gnt",   32'(arb_if.gnt),       32'd0);
        check("reset_valid", 32'(arb_if.gnt_valid), 32'd0);
        check("reset_idx",   32'(arb_if.gnt_idx),   32'd0);

        // First grant, one cycle latency
        cycle(4'b0100, 1'b0, 1'b0);
        check("first_gnt",   32'(arb_if.gnt),       32'b0100);
        check("first_idx",   32'(arb_if.gnt_idx),   32'd2);
        check("first_valid", 32'(arb_if.gnt_valid), 32'd1);

        // Saturated rotation with release every cycle
        cycle(4'b0000, 1'b0, 1'b1);
        cycle(4'b1111, 1'b0, 1'b0);
        check("sat_first", 32'(arb_if.gnt), 32'b0001);
        for (int i = 0; i < 4; i++) begin
            cycle(4'b1111, 1'b1, 1'b0);
            check("sat_seq", 32'(arb_if.gnt), 32'(sat_exp[i]));
        end

        // Wrap-around after index 3
        cycle(4'b0000, 1'b0, 1'b1);
        cycle(4'b1000, 1'b0, 1'b0);
        check("wrap_pre", 32'(arb_if.gnt), 32'b1000);
        cycle(4'b0011, 1'b1, 1'b0);
        check("wrap_gnt", 32'(arb_if.gnt), 32'b0001);

        // Sole requester released: idle gap, then re-grant
        cycle(4'b0000, 1'b0, 1'b1);
        cycle(4'b0010, 1'b0, 1'b0);
        cycle(4'b0010, 1'b1, 1'b0);
        check("sole_gap",   32'(arb_if.gnt), 32'd0);
        cycle(4'b0010, 1'b0, 1'b0);
        check("sole_again", 32'(arb_if.gnt), 32'b0010);

        // Implicit release by withdrawn request
        cycle(4'b1000, 1'b0, 1'b0);
        check("implicit_gnt", 32'(arb_if.gnt),     32'b1000);
        check("implicit_idx", 32'(arb_if.gnt_idx), 32'd3);

        // Reset mid-grant
        cycle(4'b0000, 1'b0, 1'b1);
        cycle(4'b0100, 1'b0, 1'b0);
        check("midrst_pre",  32'(arb_if.gnt), 32'b0100);
        cycle(4'b1111, 1'b0, 1'b1);
        check("midrst_zero", 32'(arb_if.gnt), 32'd0);
        cycle(4'b1111, 1'b0, 1'b0);
        check("midrst_post", 32'(arb_if.gnt), 32'b0001);

        // Release while idle is ignored
        cycle(4'b0000, 1'b0, 1'b1);
        cycle(4'b0000, 1'b1, 1'b0);
        check("idle_release", 32'(arb_if.gnt), 32'd0);

        // Grant held while other requests change
        cycle(4'b0001, 1'b0, 1'b0);
        cycle(4'b1111, 1'b0, 1'b0);
        check("hold_gnt", 32'(arb_if.gnt), 32'b0001);
        cycle(4'b0111, 1'b0, 1'b0);
        check("hold_gnt2", 32'(arb_if.gnt), 32'b0001);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            cycle(N'($urandom_range(0, 15)),
                  ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 39) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
